// File: rtl/uart_rx_if.sv
// Receiver-side signal bundle: serial line in, decoded byte and status pulses out.
// dbgState mirrors the receiver FSM state for observation.
interface uart_rx_if #(
   parameter int C_UART_DATA_WIDTH = 8
);
   logic                         rx;
   logic                         UART_valid;
   logic                         UART_err;
   logic [C_UART_DATA_WIDTH-1:0] UART_msg;
   logic [2:0]                   dbgState;

   // Handshake: UART_valid / UART_err are single-cycle strobes with no ready;
   // the consumer must take UART_msg in the cycle UART_valid is high.
   modport master (
      input  rx,
      output UART_valid, UART_err, UART_msg, dbgState
   );

   modport slave (
      output rx,
      input  UART_valid, UART_err, UART_msg, dbgState
   );
endinterface

// File: rtl/uart_rx.sv
// 8N1 serial receiver: 2-FF synchronizer, mid-bit sampling, framing-error detection.
// A stop bit sampled low parks the FSM in BREAK until the line returns high.
module uart_rx #(
   parameter int C_CLK_FRQ         = 100_000_000,
   parameter int C_UART_RATE       = 115_200,
   parameter int C_UART_DATA_WIDTH = 8
) (
   input  logic       clk,
   input  logic       rstb,
   uart_rx_if.master  uart
);
   localparam int CLKS_PER_BIT = C_CLK_FRQ / C_UART_RATE;
   localparam int HALF_BIT     = CLKS_PER_BIT / 2;
   localparam int CNT_W        = $clog2(CLKS_PER_BIT);
   localparam int IDX_W        = (C_UART_DATA_WIDTH > 1) ? $clog2(C_UART_DATA_WIDTH) : 1;

   localparam logic [CNT_W-1:0] BIT_END  = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] HALF_END = CNT_W'(HALF_BIT - 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(C_UART_DATA_WIDTH - 1);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      START = 3'd1,
      DATA  = 3'd2,
      STOP  = 3'd3,
      BREAK = 3'd4
   } rxState_t;

   rxState_t                     state, stateNext;
   logic                         rxMeta, rxS;
   logic [CNT_W-1:0]             cnt, cntNext;
   logic [IDX_W-1:0]             idx, idxNext;
   logic [C_UART_DATA_WIDTH-1:0] shiftReg, shiftNext;
   logic [C_UART_DATA_WIDTH-1:0] msgNext;
   logic                         validNext, errNext;

   assign uart.dbgState = state;

   always_ff @(posedge clk) begin
      if (rstb) begin
         rxMeta          <= 1'b1;
         rxS             <= 1'b1;
         state           <= IDLE;
         cnt             <= '0;
         idx             <= '0;
         shiftReg        <= '0;
         uart.UART_valid <= 1'b0;
         uart.UART_err   <= 1'b0;
         uart.UART_msg   <= '0;
      end else begin
         rxMeta          <= uart.rx;
         rxS             <= rxMeta;
         state           <= stateNext;
         cnt             <= cntNext;
         idx             <= idxNext;
         shiftReg        <= shiftNext;
         uart.UART_valid <= validNext;
         uart.UART_err   <= errNext;
         uart.UART_msg   <= msgNext;
      end
   end

   always_comb begin
      stateNext = state;
      cntNext   = cnt;
      idxNext   = idx;
      shiftNext = shiftReg;
      msgNext   = uart.UART_msg;
      validNext = 1'b0;
      errNext   = 1'b0;
      case (state)
         IDLE: begin
            cntNext = '0;
            if (!rxS) stateNext = START;
         end
         START: begin
            // Re-check the line half a bit in so short glitches are dropped.
            if (cnt == HALF_END) begin
               cntNext = '0;
               if (!rxS) begin
                  stateNext = DATA;
                  idxNext   = '0;
               end else begin
                  stateNext = IDLE;
               end
            end else begin
               cntNext = cnt + CNT_W'(1);
            end
         end
         DATA: begin
            if (cnt == BIT_END) begin
               cntNext        = '0;
               shiftNext[idx] = rxS;
               if (idx == IDX_LAST) stateNext = STOP;
               else                 idxNext   = idx + IDX_W'(1);
            end else begin
               cntNext = cnt + CNT_W'(1);
            end
         end
         STOP: begin
            // Leave at mid-stop-bit so a start bit right behind it is caught.
            if (cnt == BIT_END) begin
               cntNext = '0;
               if (rxS) begin
                  msgNext   = shiftReg;
                  validNext = 1'b1;
                  stateNext = IDLE;
               end else begin
                  errNext   = 1'b1;
                  stateNext = BREAK;
               end
            end else begin
               cntNext = cnt + CNT_W'(1);
            end
         end
         BREAK: begin
            cntNext = '0;
            if (rxS) stateNext = IDLE;
         end
         default: begin
            stateNext = IDLE;
            cntNext   = '0;
         end
      endcase
   end
endmodule

// File: doc/uart_rx.md
# uart_rx

Serial receiver for the music keyboard link: samples the asynchronous RX line from the host at `C_UART_RATE` baud and reassembles 8N1 frames. It also flags framing errors. It sits directly upstream of `control` and drives its `UART_valid`, `UART_err` and `UART_msg` inputs.

## Interface
- `C_CLK_FRQ`, 100_000_000, main clock frequency [Hz].
- `C_UART_RATE`, 115_200, baud rate.
- `C_UART_DATA_WIDTH`, 8, data bits per frame.
- Derived: `CLKS_PER_BIT` = `C_CLK_FRQ / C_UART_RATE` (integer division; 868 at defaults) and `HALF_BIT` = `CLKS_PER_BIT / 2` (434).

Ports:
- `clk`  in  1  main clock.
- `rstb`  in  1  reset; one clock; reset is synchronous and active-high (`rstb`=1 resets on the rising edge of `clk`).
- `rx`  in  1  asynchronous serial line; idle high.
- `UART_valid`  out  1  one-cycle pulse: `UART_msg` was updated with a good frame.
- `UART_err`  out  1  one-cycle pulse: framing error (stop bit sampled low).
- `UART_msg`  out  `C_UART_DATA_WIDTH`  last correctly received byte.

## Operation
- The `rx` input passes through a 2-FF synchronizer. Both FFs reset to 1. All decisions use the synchronized bit `rx_s`.
- Frame format: 1 start bit (0), `C_UART_DATA_WIDTH` data bits LSB first, 1 stop bit (1), no parity.
- A single bit counter counts 0..N-1. A phase ends in the cycle where the counter equals N-1, after which the counter clears.
- State machine:
  - **IDLE**: counter held at 0. `rx_s`=0 → START.
  - **START**: count `HALF_BIT` cycles, then sample. If `rx_s`=0 (valid start) → DATA with bit index 0. If `rx_s`=1 (glitch) → IDLE, with no output.
  - **DATA**: count `CLKS_PER_BIT` cycles, sample `rx_s` into shift register position [index], increment index. After bit `C_UART_DATA_WIDTH`-1 is sampled → STOP.
  - **STOP**: count `CLKS_PER_BIT` cycles, then sample.
    - `rx_s`=1: load `UART_msg` from the shift register, pulse `UART_valid`, → IDLE.
    - `rx_s`=0: pulse `UART_err`, leave `UART_msg` unchanged, → BREAK.
  - **BREAK**: wait for `rx_s`=1 for at least 1 cycle → IDLE. Falling edges seen here are not treated as start bits.
- Returning to IDLE directly after the mid-stop-bit sample lets back-to-back frames (no idle gap) be received.
- `UART_valid` and `UART_err` are never high in the same cycle, and each is never high for more than 1 cycle.
- Reset: state IDLE, counter 0, index 0, shift register 0. Outputs reset to `UART_valid`=0, `UART_err`=0, `UART_msg`=0. Reset mid-frame aborts the frame silently.

## Timing
- All outputs are registered.
- Latency from `rx` falling edge to the `UART_valid`/`UART_err` pulse at defaults is 2 (sync) + 434 + 8·868 + 868 + 1 = 8249 cycles, with ±1 cycle edge-alignment uncertainty.
- `UART_msg` changes in the same cycle `UART_valid` rises and holds until the next good frame.
- Data bits are sampled at the centre of each bit (±1 cycle). Receiver tolerance is ≥ ±3 % baud mismatch at defaults.
- Minimum frame spacing: stop bit duration only (10 bit-times per byte).
- There is no backpressure. The consumer must accept `UART_valid` in the same cycle.

## Test plan
- **Reset**: hold `rstb`=1 for 20 cycles with `rx`=1. Required: `UART_msg`=0x00 and `UART_valid`=`UART_err`=0. After release, with the line idle for 1 ms, no pulses occur.
- **Single frame**: send 0x7A at 115200. Required: exactly one `UART_valid` pulse 8249±2 cycles after the start edge, `UART_msg`=0x7A, `UART_err` stays 0.
- **Back-to-back**: send 0x91 then 0x6E with no idle gap. Required: two `UART_valid` pulses 8680±2 cycles apart, with `UART_msg`=0x91 then 0x6E.
- **Glitch**: drive `rx` low for 200 cycles, then high. Required: no pulse, and a following 0x02 frame is received correctly.
- **Framing error**: after 0x7A, send 0x55 with the stop bit forced to 0 and the line held low for 2 bit-times. Required: one `UART_err` pulse, no `UART_valid`, `UART_msg` stays 0x7A. A subsequent 0x10 frame gives `UART_valid` with `UART_msg`=0x10.
- **Reset mid-frame and baud skew**:
  - Assert `rstb` during data bit 4 of 0xAA. Required: no pulse and `UART_msg`=0x00. A next frame 0xC3 sent at +2 % baud is received as 0xC3.
